// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the BCD-to-binary converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VAL = 4'd3;
  function automatic int bcd_bin_width(input int digits);
    longint m;
    int w;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    w = 0;
    while ((longint'(1) << w) < m) w++;
    return w;
  endfunction
endpackage

// File: rtl/bcd_nibble_adjust.sv
// bcd_nibble_adjust: subtract 3 from a nibble that reached 8 or more after a right shift
module bcd_nibble_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] n,
  output logic [3:0] q
);
  assign q = n >= BCD_ADJ_THRESH ? n - BCD_ADJ_VAL : n;
endmodule

// File: rtl/bcd_binary.sv
// bcd_binary: sequential reverse double dabble BCD-to-binary converter with illegal-digit flag
module bcd_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  error
);
  localparam int SW = 4*DIGITS + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  if (BIN_W < bcd_bin_width(DIGITS)) begin : g_width_check
    $error("BIN_W too small to hold the largest DIGITS-digit decimal value");
  end
  bcd_state_t state, state_nx;
  logic [SW-1:0] sr, t, t_adj;
  logic [CW-1:0] cnt;
  logic illegal;
  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX) illegal = 1'b1;
  end
  assign t = sr >> 1;
  assign t_adj[BIN_W-1:0] = t[BIN_W-1:0];
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_nibble_adjust u_adj (.n(t[BIN_W+4*d +: 4]), .q(t_adj[BIN_W+4*d +: 4]));
  end
  always_comb begin
    state_nx = state == IDLE  ? (start ? (illegal ? DONE : SHIFT) : IDLE) :
               state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      bin_out <= '0;
      error   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          error <= illegal;
          if (illegal) bin_out <= '0;
          else begin
            sr  <= {bcd_in, {BIN_W{1'b0}}};
            cnt <= CW'(BIN_W);
          end
        end
        SHIFT: begin
          sr  <= cnt > CW'(1) ? t_adj : t;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) bin_out <= t[BIN_W-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_binary.sv
// tb_bcd_binary: randomized self-checking bench against a decimal arithmetic model
module tb_bcd_binary;
  localparam int D = 4;
  localparam int W = 14;
  logic clk = 1'b0;
  logic reset, start;
  logic [4*D-1:0] bcd_in;
  logic busy, done, error;
  logic [W-1:0] bin_out;
  int checks = 0;
  int errors = 0;
  bcd_binary #(.DIGITS(D), .BIN_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic convert(input logic [4*D-1:0] b, input int poke);
    int v, cyc, busy_n;
    bit ill;
    v = 0;
    ill = 0;
    for (int i = D - 1; i >= 0; i--) begin
      if (b[4*i +: 4] > 9) ill = 1;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    @(negedge clk);
    bcd_in = b;
    start = 1'b1;
    cyc = 0;
    busy_n = 0;
    @(negedge clk);
    start = 1'b0;
    chk("err_on_accept", error, ill);
    while (1) begin
      busy_n += int'(busy);
      if (done || cyc > 40) break;
      cyc++;
      if (cyc == poke) begin
        start = 1'b1;
        bcd_in = 16'h0999;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("latency", cyc, ill ? 0 : W);
    chk("busy_cycles", busy_n, ill ? 1 : W + 1);
    chk("bin_out", bin_out, ill ? 0 : v);
    chk("error", error, ill);
    if (!ill) chk("sr_bcd_zero", dut.sr[4*D+W-1:W], 0);
    @(negedge clk);
    chk("done_one_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask
  initial begin
    int dones;
    logic [4*D-1:0] r;
    reset = 1'b1;
    start = 1'b0;
    bcd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_err", error, 0);
    reset = 1'b0;
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("idle_no_done", dones, 0);
    convert(16'h9999, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_bin", bin_out, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    convert(16'h0000, 0);
    convert(16'h1234, 0);
    convert(16'h0010, 0);
    convert(16'h12A4, 0);
    convert(16'h0007, 0);
    convert(16'h0500, 4);
    @(negedge clk);
    bcd_in = 16'h8888;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_bin", bin_out, 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (16) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("midrst_no_done", dones, 0);
    convert(16'h0042, 0);
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) r[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      convert(r, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
